// File: rtl/ex_stage_alu.sv
// rtl/ex_stage_alu.sv - RISC-V execute-stage ALU with a 2-entry valid/ready output buffer.
// Results are computed on the input side and only the registered head entry drives the outputs.
module ex_stage_alu #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alu_control,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [4:0]      rd_in,
  input  logic            reg_write_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            zero,
  output logic            illegal_op,
  output logic [4:0]      rd_out,
  output logic            reg_write_out
);

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;
    logic [4:0]      rd;
    logic            reg_write;
  } entry_t;

  entry_t     buf_q [2];
  entry_t     new_entry;
  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       push, pop;

  always_comb begin
    new_entry         = '0;
    new_entry.rd      = rd_in;
    unique case (alu_control)
      3'b000:  new_entry.result = src_a + src_b;
      3'b001:  new_entry.result = src_a - src_b;
      3'b010:  new_entry.result = src_a & src_b;
      3'b011:  new_entry.result = src_a | src_b;
      3'b101:  new_entry.result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: new_entry.illegal = 1'b1;
    endcase
    new_entry.zero      = (new_entry.result == '0);
    new_entry.reg_write = reg_write_in & ~new_entry.illegal;
  end

  // in_ready depends only on registered count (plus reset), never on out_ready.
  assign in_ready  = (count_q != 2'(DEPTH)) & ~rst;
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      if (push && !pop)      count_d = count_q + 2'd1;
      else if (pop && !push) count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) buf_q[i] <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) buf_q[wr_ptr_q] <= new_entry;
    end
  end

  assign alu_result    = buf_q[rd_ptr_q].result;
  assign zero          = buf_q[rd_ptr_q].zero;
  assign illegal_op    = buf_q[rd_ptr_q].illegal;
  assign rd_out        = buf_q[rd_ptr_q].rd;
  assign reg_write_out = buf_q[rd_ptr_q].reg_write;

  count_bound_a: assert property (@(posedge clk) disable iff (rst) count_q <= 2'd2);

endmodule

// File: doc/ex_stage_alu.md
Name: ex_stage_alu

Overview:
- Execute stage directly downstream of the ALU control unit in the RISC-V datapath.
- Consumes the 3-bit ALU control code plus operands, computes the result and a zero flag, and holds results in a 2-entry output buffer feeding EX/MEM.
- Uses a valid/ready handshake on both sides so memory-stage stalls back-pressure the decode path without losing or reordering results.
- Supports a synchronous pipeline flush for branch mispredict and redirect.

Parameters:
- XLEN, 32, operand/result width.
- DEPTH, 2, output buffer entries (fixed at 2; other values unsupported).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents a valid operation.
- in_ready  output  1  stage can accept an operation this cycle.
- alu_control  input  3  000 add, 001 sub, 010 and, 011 or, 101 slt; all other codes reserved.
- src_a  input  XLEN  operand A.
- src_b  input  XLEN  operand B (register or immediate, already muxed).
- rd_in  input  5  destination register index.
- reg_write_in  input  1  writeback enable.
- flush  input  1  discard all buffered and incoming operations.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  downstream consumes the head entry this cycle.
- alu_result  output  XLEN  head entry result.
- zero  output  1  head entry result == 0.
- illegal_op  output  1  head entry used a reserved alu_control code.
- rd_out  output  5  head entry rd.
- reg_write_out  output  1  head entry writeback enable; forced 0 when illegal_op.

Behaviour:
- Reset (rst=1 at edge):
  - count=0, read/write pointers=0.
  - out_valid=0; alu_result, zero, illegal_op, rd_out and reg_write_out all 0.
  - in_ready=0 during the reset cycle and 1 on the first cycle after reset deasserts.
  - Reset overrides flush and all handshakes.
- Arithmetic, computed combinationally on the input side and stored at push:
  - add: a+b, modulo 2^XLEN, no overflow flag.
  - sub: a-b, modulo 2^XLEN, no overflow flag.
  - and: bitwise a&b.
  - or: bitwise a|b.
  - slt: result 1 if $signed(a) < $signed(b), else 0, zero-extended to XLEN.
  - Reserved code: result 0, illegal_op=1, zero=1, reg_write stored as 0.
- Push and pop:
  - push = in_valid & in_ready & !flush.
  - pop = out_valid & out_ready & !flush.
- in_ready = (count < 2) & !rst. in_ready is a function of registered state only; no combinational path from out_ready.
- out_valid = (count != 0). Output fields come straight from the head entry register.
- Latency: an operation accepted at edge N is visible with out_valid=1 after edge N, even when the buffer was empty. No same-cycle bypass.
- Throughput: 1 op/cycle when out_ready is held high.
- count transitions:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged; allowed at count=1. Not possible at count=2 because in_ready=0.
  - Pointers wrap modulo 2.
- Full (count=2): in_ready=0; upstream must hold its inputs stable.
- Empty (count=0): out_valid=0; output fields hold their last values (don't-care, but must not be X after reset).
- Stall: while out_valid=1 and out_ready=0, all head outputs remain bit-stable.
- Ordering: strict FIFO.
- Flush (flush=1, rst=0):
  - Next-state count=0.
  - Any same-cycle input is dropped and no pop is counted.
  - out_valid=0 the following cycle; in_ready=1 the following cycle.
- Illegal-state guard: count never exceeds 2. A verification assertion checks this.

Test Plan:
- Reset then single op: add a=5, b=7, rd=3, out_ready=1 -> next cycle out_valid=1, alu_result=12, zero=0, rd_out=3, reg_write_out=1; following cycle out_valid=0.
- Back-to-back stream of sub 10-10, slt -1<1, or 0xF0|0x0F with out_ready=1 -> results 0 (zero=1), 1, 0xFF on consecutive cycles; in_ready stays 1 throughout.
- Back-pressure: out_ready=0 while pushing three ops (add 1+1, and 0xC&0xA, sub 0-1) -> in_ready drops after the 2nd accept and the 3rd is held. Release out_ready -> 2, 0x8, 0xFFFFFFFF emerge in order, with outputs stable during the stall.
- Simultaneous push/pop at count=1 -> count stays 1 and the result sequence is unchanged.
- Flush with count=2 plus a concurrent in_valid -> next cycle out_valid=0, in_ready=1, and none of the three ops ever appear.
- Reserved code alu_control=3'b111, a=3, b=4, reg_write_in=1 -> alu_result=0, zero=1, illegal_op=1, reg_write_out=0.
